// File: rtl/cmp_crossing_detector.sv
// Debounced HIGH/LOW level tracker behind a 4-bit magnitude comparator, with rise/fall events
// over valid/ready and saturating per-class counters. Optional macro: CMP_ONEHOT_CHECK_EN.
module cmp_crossing_detector #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_evt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic             err
);

  localparam int unsigned StreakW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] StUnk  = 2'b00;
  localparam logic [1:0] StLow  = 2'b01;
  localparam logic [1:0] StHigh = 2'b10;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [StreakW-1:0] streak_inc;
  logic               out_valid_q, out_valid_d;
  logic               out_evt_q, out_evt_d;
  logic [CNT_W-1:0]   cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0]   cnt_lt_q, cnt_lt_d;
  logic [CNT_W-1:0]   cnt_eq_q, cnt_eq_d;

  logic accept;
  logic sample;
  logic is_gt, is_lt, is_eq;
  logic evt_fire, evt_rise;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef CMP_ONEHOT_CHECK_EN
  logic onehot;
  logic err_q, err_d;

  assign onehot = (cmp_gt + cmp_lt + cmp_eq) == 2'd1;
  // Non-one-hot samples only raise err; they never reach the FSM or counters.
  assign sample = accept && onehot;
  assign is_gt  = cmp_gt;
  assign is_lt  = cmp_lt;
  assign is_eq  = cmp_eq;

  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end else if (accept && !onehot) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_cmp_eq;

  // Priority gt > lt > eq; all-zero flags fall through to eq, so cmp_eq is redundant here.
  assign unused_cmp_eq = cmp_eq;
  assign sample        = accept;
  assign is_gt         = cmp_gt;
  assign is_lt         = !cmp_gt && cmp_lt;
  assign is_eq         = !cmp_gt && !cmp_lt;
  assign err           = 1'b0;
`endif

  assign streak_inc = streak_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    evt_fire = 1'b0;
    evt_rise = 1'b0;
    if (sample) begin
      case (state_q)
        StUnk: begin
          streak_d = '0;
          if (is_gt) begin
            state_d = StHigh;
          end else if (is_lt) begin
            state_d = StLow;
          end
        end
        StLow: begin
          if (is_gt) begin
            if (streak_inc == StreakW'(DEBOUNCE)) begin
              state_d  = StHigh;
              streak_d = '0;
              evt_fire = 1'b1;
              evt_rise = 1'b1;
            end else begin
              streak_d = streak_inc;
            end
          end else begin
            streak_d = '0;
          end
        end
        StHigh: begin
          if (is_lt) begin
            if (streak_inc == StreakW'(DEBOUNCE)) begin
              state_d  = StLow;
              streak_d = '0;
              evt_fire = 1'b1;
              evt_rise = 1'b0;
            end else begin
              streak_d = streak_inc;
            end
          end else begin
            streak_d = '0;
          end
        end
        default: begin
          state_d  = StUnk;
          streak_d = '0;
        end
      endcase
    end
  end

  // A new event on the same edge as a consume keeps out_valid high with the new type.
  always_comb begin
    out_valid_d = out_valid_q;
    out_evt_d   = out_evt_q;
    if (evt_fire) begin
      out_valid_d = 1'b1;
      out_evt_d   = evt_rise;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // clr beats a simultaneous accept: the sample still drives the FSM but is not counted.
  always_comb begin
    cnt_gt_d = cnt_gt_q;
    cnt_lt_d = cnt_lt_q;
    cnt_eq_d = cnt_eq_q;
    if (clr) begin
      cnt_gt_d = '0;
      cnt_lt_d = '0;
      cnt_eq_d = '0;
    end else if (sample) begin
      if (is_gt && (cnt_gt_q != CntMax)) begin
        cnt_gt_d = cnt_gt_q + 1'b1;
      end
      if (is_lt && (cnt_lt_q != CntMax)) begin
        cnt_lt_d = cnt_lt_q + 1'b1;
      end
      if (is_eq && (cnt_eq_q != CntMax)) begin
        cnt_eq_d = cnt_eq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUnk;
      streak_q    <= '0;
      out_valid_q <= 1'b0;
      out_evt_q   <= 1'b0;
      cnt_gt_q    <= '0;
      cnt_lt_q    <= '0;
      cnt_eq_q    <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      out_valid_q <= out_valid_d;
      out_evt_q   <= out_evt_d;
      cnt_gt_q    <= cnt_gt_d;
      cnt_lt_q    <= cnt_lt_d;
      cnt_eq_q    <= cnt_eq_d;
    end
  end

  assign state     = state_q;
  assign out_valid = out_valid_q;
  assign out_evt   = out_evt_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_lt    = cnt_lt_q;
  assign cnt_eq    = cnt_eq_q;

endmodule
